// File: rtl/irr_pkg.sv
// Shared types and default constants for the irrigation sequencer.
package irr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } irr_state_e;

  localparam int IRR_W         = 4;
  localparam int IRR_NZONES    = 3;
  localparam int IRR_GAP_TICKS = 2;

  // The drain counter only has to count 0..GAP_TICKS-1.
  function automatic int gap_cnt_width(input int gap_ticks);
    return (gap_ticks < 2) ? 1 : $clog2(gap_ticks);
  endfunction

endpackage

// File: rtl/irr_down_timer.sv
// Loadable W-bit down counter that stops at zero; used as the zone run timer.
module irr_down_timer
  import irr_pkg::*;
#(
  parameter int W = IRR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Counter register: clear beats load, load beats decrement, never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1'b1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/irrigation_sequencer.sv
// Waters each requested zone in ascending order for its programmed number of
// ticks, with a valve-off drain gap between zones.
module irrigation_sequencer
  import irr_pkg::*;
#(
  parameter int W         = IRR_W,
  parameter int NZONES    = IRR_NZONES,
  parameter int GAP_TICKS = IRR_GAP_TICKS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NZONES-1:0]     req,
  input  logic [NZONES*W-1:0]   dur,
  output logic [NZONES-1:0]     valve,
  output logic [1:0]            zone_id,
  output logic [W-1:0]          remaining,
  output logic                  busy,
  output logic                  done
);

  localparam int GW = gap_cnt_width(GAP_TICKS);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  irr_state_e          r_state;
  irr_state_e          w_state_nxt;
  logic [NZONES-1:0]   r_pending;
  logic [NZONES-1:0]   w_pending_nxt;
  logic [1:0]          r_zone_id;
  logic [1:0]          w_zone_id_nxt;
  logic [GW-1:0]       r_gap_cnt;
  logic [GW-1:0]       w_gap_cnt_nxt;

  logic [1:0]          w_sel;
  logic [NZONES-1:0]   w_sel_mask;
  logic [NZONES-1:0]   w_pending_left;
  logic [W-1:0]        w_sel_dur;

  logic                w_abort_act;
  logic                w_tmr_load;
  logic                w_tmr_en;
  logic                w_tmr_clear;
  logic [W-1:0]        w_tmr_count;
  logic                w_tmr_zero;

  assign w_abort_act = abort && (r_state != ST_IDLE);

  irr_down_timer #(
    .W (W)
  ) u_zone_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_tmr_clear),
    .i_load     (w_tmr_load),
    .i_load_val (w_sel_dur),
    .i_en       (w_tmr_en),
    .o_count    (w_tmr_count),
    .o_zero     (w_tmr_zero)
  );

  // Lowest-index pending zone and its programmed duration.
  always_comb begin
    w_sel     = 2'd0;
    w_sel_dur = '0;
    for (int k = NZONES - 1; k >= 0; k--) begin
      w_sel = r_pending[k] ? 2'(k) : w_sel;
    end
    for (int k = 0; k < NZONES; k++) begin
      w_sel_dur = (2'(k) == w_sel) ? dur[k*W +: W] : w_sel_dur;
    end
    w_sel_mask     = NZONES'(1'b1) << w_sel;
    w_pending_left = r_pending & ~w_sel_mask;
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_zone_id_nxt = r_zone_id;
    w_gap_cnt_nxt = r_gap_cnt;
    w_tmr_load    = 1'b0;
    w_tmr_en      = 1'b0;
    w_tmr_clear   = 1'b0;

    if (w_abort_act) begin
      w_state_nxt   = ST_IDLE;
      w_pending_nxt = '0;
      w_gap_cnt_nxt = '0;
      w_tmr_clear   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            w_pending_nxt = req;
            w_state_nxt   = (req != '0) ? ST_LOAD : ST_DONE;
          end else begin
            w_state_nxt   = ST_IDLE;
          end
        end

        ST_LOAD: begin
          w_zone_id_nxt = w_sel;
          w_pending_nxt = w_pending_left;
          w_tmr_load    = 1'b1;
          // A zero-length zone is skipped without ever opening its valve.
          if (w_sel_dur == '0) begin
            w_state_nxt = (w_pending_left != '0) ? ST_LOAD : ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end

        ST_RUN: begin
          w_tmr_en = tick;
          if (tick && ((w_tmr_count == W'(1'b1)) || w_tmr_zero)) begin
            w_state_nxt   = ST_GAP;
            w_gap_cnt_nxt = '0;
          end else begin
            w_state_nxt   = ST_RUN;
          end
        end

        ST_GAP: begin
          if ((GAP_TICKS == 0) || (tick && (r_gap_cnt == GAP_LAST))) begin
            w_state_nxt = (r_pending != '0) ? ST_LOAD : ST_DONE;
          end else if (tick) begin
            w_gap_cnt_nxt = r_gap_cnt + GW'(1'b1);
          end else begin
            w_state_nxt = ST_GAP;
          end
        end

        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end

        default: begin
          w_state_nxt   = ST_IDLE;
          w_pending_nxt = '0;
          w_tmr_clear   = 1'b1;
        end
      endcase
    end
  end

  // State and sequencing registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_zone_id <= 2'd0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_zone_id <= w_zone_id_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  // Outputs decoded from registered state only, so inputs never reach them combinationally.
  always_comb begin
    if (r_state == ST_RUN) begin
      valve     = NZONES'(1'b1) << r_zone_id;
      remaining = w_tmr_count;
    end else begin
      valve     = '0;
      remaining = '0;
    end
    zone_id = (r_state == ST_LOAD) ? w_sel : r_zone_id;
    busy    = (r_state != ST_IDLE);
    done    = (r_state == ST_DONE);
  end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Randomised and directed bench for irrigation_sequencer against a queue-based zone-schedule model.
module tb_irrigation_sequencer;

  localparam int W  = 4;
  localparam int NZ = 3;
  localparam int GT = 2;
  localparam int TRACE = 4096;

  localparam int A_IDLE = 0;
  localparam int A_LOAD = 1;
  localparam int A_RUN  = 2;
  localparam int A_GAP  = 3;
  localparam int A_DONE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1;
  logic            tick  = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [NZ-1:0]   req   = '0;
  logic [NZ*W-1:0] dur   = '0;
  logic [NZ-1:0]   valve;
  logic [1:0]      zone_id;
  logic [W-1:0]    remaining;
  logic            busy;
  logic            done;

  irrigation_sequencer #(.W(W), .NZONES(NZ), .GAP_TICKS(GT)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .abort     (abort),
    .req       (req),
    .dur       (dur),
    .valve     (valve),
    .zone_id   (zone_id),
    .remaining (remaining),
    .busy      (busy),
    .done      (done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // model: current activity, zone being served, ticks left, and zones still to visit
  int m_act  = A_IDLE;
  int m_zone = 0;
  int m_zid  = 0;
  int m_left = 0;
  int m_q[$];

  logic [NZ*W-1:0] n_dur = '0;
  logic [NZ-1:0]   n_req = '0;

  logic [NZ-1:0] tr_valve [TRACE];
  int            tr_done  [TRACE];
  int            tr_busy  [TRACE];
  int            tr_rem   [TRACE];
  int            tr_zid   [TRACE];

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  function automatic int zone_dur(input int z);
    return int'(dur[z*W +: W]);
  endfunction

  task automatic next_zone();
    if (m_q.size() == 0) begin
      m_act = A_DONE;
    end else begin
      m_act  = A_LOAD;
      m_zone = m_q.pop_front();
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_act = A_IDLE; m_q.delete(); m_zid = 0; m_left = 0;
    end else if (abort && m_act != A_IDLE) begin
      m_act = A_IDLE; m_q.delete(); m_left = 0;
    end else begin
      case (m_act)
        A_IDLE: if (start && !abort) begin
          for (int z = 0; z < NZ; z++) if (req[z]) m_q.push_back(z);
          next_zone();
        end
        A_LOAD: begin
          m_zid  = m_zone;
          m_left = zone_dur(m_zone);
          if (m_left == 0) next_zone(); else m_act = A_RUN;
        end
        A_RUN: if (tick) begin
          m_left--;
          if (m_left == 0) begin m_act = A_GAP; m_left = GT; end
        end
        A_GAP: begin
          if (tick && m_left > 0) m_left--;
          if (m_left == 0) next_zone();
        end
        default: m_act = A_IDLE;
      endcase
    end
    cyc++;
  endtask

  task automatic go(input bit t, input bit s, input bit a, input bit r);
    #2;
    tick = t; start = s; abort = a; reset = r; req = n_req; dur = n_dur;
    @(posedge clk);
    model_step();
  endtask

  // single compare process: every cycle against the model
  initial begin
    int ev;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        ev = (m_act == A_RUN) ? (1 << m_zone) : 0;
        chk("valve", int'(valve), ev);
        chk("zone_id", int'(zone_id), (m_act == A_LOAD) ? m_zone : m_zid);
        chk("remaining", int'(remaining), (m_act == A_RUN) ? m_left : 0);
        chk("busy", int'(busy), int'(m_act != A_IDLE));
        chk("done", int'(done), int'(m_act == A_DONE));
        if (cyc < TRACE) begin
          tr_valve[cyc] = valve;
          tr_done[cyc]  = int'(done);
          tr_busy[cyc]  = int'(busy);
          tr_rem[cyc]   = int'(remaining);
          tr_zid[cyc]   = int'(zone_id);
        end
      end
    end
  end

  initial begin
    int n;
    int m;
    logic [NZ-1:0] exp39 [13];
    exp39 = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000,
              3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};

    go(1'b1, 1'b1, 1'b1, 1'b1);
    chk_en = 1'b1;
    go(1'b1, 1'b0, 1'b0, 1'b1);
    go(1'b0, 1'b0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_valve", int'(tr_valve[2]), 0);
    chk("rst_busy", tr_busy[2], 0);
    chk("rst_done", tr_done[2], 0);
    chk("rst_zone", tr_zid[2], 0);

    // two zones, tick every cycle, second start mid-run must be ignored
    n_req = 3'b101; n_dur = 12'h203;
    n = cyc;
    go(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      if (i == 3) begin
        n_req = 3'b111;
        go(1'b1, 1'b1, 1'b0, 1'b0);
      end else begin
        go(1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
    for (int i = 1; i <= 13; i++) begin
      chk("seq_valve", int'(tr_valve[n+i]), int'(exp39[i-1]));
      chk("seq_done", tr_done[n+i], (i == 12) ? 1 : 0);
    end
    chk("seq_rem_first", tr_rem[n+2], 3);
    chk("seq_zone_second", tr_zid[n+8], 2);

    // single zero-duration zone: LOAD then DONE, no valve
    n_req = 3'b010; n_dur = 12'h505;
    n = cyc;
    go(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) go(1'b1, 1'b0, 1'b0, 1'b0);
    chk("skip_done_early", tr_done[n+1], 0);
    chk("skip_done", tr_done[n+2], 1);
    chk("skip_done_late", tr_done[n+3], 0);
    for (int i = 1; i <= 3; i++) chk("skip_valve", int'(tr_valve[n+i]), 0);

    // empty request mask: straight to DONE
    n_req = 3'b000;
    n = cyc;
    go(1'b0, 1'b1, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b0, 1'b0);
    chk("empty_done", tr_done[n+1], 1);
    chk("empty_valve", int'(tr_valve[n+1]), 0);
    chk("empty_idle", tr_busy[n+2], 0);

    // abort after five slow ticks, abort beats tick and start
    n_req = 3'b001; n_dur = 12'h00F;
    n = cyc;
    go(1'b0, 1'b1, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) go((i % 4) == 0, 1'b0, 1'b0, 1'b0);
    go(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) go(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_rem", tr_rem[n+19], 10);
    chk("abort_valve_before", int'(tr_valve[n+19]), 1);
    chk("abort_valve", int'(tr_valve[n+20]), 0);
    chk("abort_busy", tr_busy[n+20], 0);
    for (int i = 19; i <= 24; i++) chk("abort_no_done", tr_done[n+i], 0);

    // reset mid-run at remaining 7, then a fresh cycle
    n_req = 3'b001; n_dur = 12'h009;
    n = cyc;
    go(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) go(1'b1, 1'b0, 1'b0, 1'b0);
    go(1'b1, 1'b1, 1'b1, 1'b1);
    go(1'b0, 1'b0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rstrun_rem", tr_rem[n+4], 7);
    chk("rstrun_valve_before", int'(tr_valve[n+4]), 1);
    chk("rstrun_valve", int'(tr_valve[n+5]), 0);
    chk("rstrun_rem_after", tr_rem[n+5], 0);
    chk("rstrun_busy", tr_busy[n+5], 0);
    chk("rstrun_zone", tr_zid[n+5], 0);
    n_req = 3'b100; n_dur = 12'h100;
    m = cyc;
    go(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) go(1'b1, 1'b0, 1'b0, 1'b0);
    chk("fresh_valve", int'(tr_valve[m+2]), 4);
    chk("fresh_rem", tr_rem[m+2], 1);
    chk("fresh_done", tr_done[m+5], 1);

    // randomised traffic, durations may change every cycle
    for (int i = 0; i < 3000; i++) begin
      n_req = NZ'($urandom);
      for (int z = 0; z < NZ; z++) n_dur[z*W +: W] = W'($urandom_range(0, 6));
      go(($urandom % 2) == 0, ($urandom % 6) == 0, ($urandom % 60) == 0, ($urandom % 300) == 0);
    end
    go(1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
